// File: rtl/caliptra_apb_arbiter.sv
// Two-requester round-robin APB arbiter in front of the single Caliptra APB completer.
// One full transfer per grant, registered downstream outputs, forced error completion on a hung ACCESS.
//
//   state  | meaning
//   IDLE   | sample up_psel, latch winner's request into dn_* registers
//   SETUP  | dn_psel=1, dn_penable=0, timeout counter cleared
//   ACCESS | dn_psel=1, dn_penable=1, wait for dn_pready or timeout
//   RESP   | one-cycle pready/pslverr/prdata pulse to the owning requester
module caliptra_apb_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                       core_clk,
  input  logic                       core_rst,
  input  logic [1:0]                 up_psel,
  input  logic [1:0]                 up_penable,
  input  logic [1:0]                 up_pwrite,
  input  logic [1:0][2:0]            up_pprot,
  input  logic [1:0][ADDR_WIDTH-1:0] up_paddr,
  input  logic [1:0][DATA_WIDTH-1:0] up_pwdata,
  output logic [1:0]                 up_pready,
  output logic [DATA_WIDTH-1:0]      up_prdata,
  output logic [1:0]                 up_pslverr,
  output logic                       dn_psel,
  output logic                       dn_penable,
  output logic                       dn_pwrite,
  output logic [2:0]                 dn_pprot,
  output logic [ADDR_WIDTH-1:0]      dn_paddr,
  output logic [DATA_WIDTH-1:0]      dn_pwdata,
  input  logic [DATA_WIDTH-1:0]      dn_prdata,
  input  logic                       dn_pready,
  input  logic                       dn_pslverr,
  output logic                       grant_id,
  output logic                       timeout_pulse
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam bit                   TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] TO_LAST = TO_EN ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

  logic [1:0]            state_q, state_d;
  logic                  gnt_q, gnt_d;
  logic                  last_q, last_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  pwrite_q, pwrite_d;
  logic [2:0]            pprot_q, pprot_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  slverr_q, slverr_d;
  logic                  tmo_q, tmo_d;
  logic                  gnt_sel;
  logic                  in_resp;

  // PENABLE from the requesters is deliberately not checked.
  logic unused_penable;
  assign unused_penable = ^up_penable;

  assign gnt_sel = (up_psel == 2'b11) ? ~last_q : up_psel[1];

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    pwrite_d = pwrite_q;
    pprot_d  = pprot_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    slverr_d = slverr_q;
    tmo_d    = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (|up_psel) begin
          gnt_d    = gnt_sel;
          last_d   = gnt_sel;
          pwrite_d = up_pwrite[gnt_sel];
          pprot_d  = up_pprot[gnt_sel];
          paddr_d  = up_paddr[gnt_sel];
          pwdata_d = up_pwdata[gnt_sel];
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = '0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        // Completer ready wins over a timeout on the same edge.
        if (dn_pready) begin
          rdata_d  = dn_prdata;
          slverr_d = dn_pslverr;
          tmo_d    = 1'b0;
          state_d  = S_RESP;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          rdata_d  = '0;
          slverr_d = 1'b1;
          tmo_d    = 1'b1;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      state_q  <= S_IDLE;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      pwrite_q <= 1'b0;
      pprot_q  <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      slverr_q <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      pwrite_q <= pwrite_d;
      pprot_q  <= pprot_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      rdata_q  <= rdata_d;
      slverr_q <= slverr_d;
      tmo_q    <= tmo_d;
    end
  end

  // Decoded from state so an async reset drops PSEL/PENABLE immediately.
  assign dn_psel       = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign dn_penable    = (state_q == S_ACCESS);
  assign dn_pwrite     = pwrite_q;
  assign dn_pprot      = pprot_q;
  assign dn_paddr      = paddr_q;
  assign dn_pwdata     = pwdata_q;
  assign grant_id      = gnt_q;

  assign in_resp       = (state_q == S_RESP);
  assign up_pready     = in_resp ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign up_pslverr    = (in_resp && slverr_q) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign up_prdata     = in_resp ? rdata_q : '0;
  assign timeout_pulse = in_resp && tmo_q;

endmodule

// File: doc/caliptra_apb_arbiter.md
Name: caliptra_apb_arbiter

Overview:
Two-requester APB arbiter that shares the single Caliptra APB completer port (PADDR/PSEL/PENABLE/...) between two upstream APB requesters.
Port 0 is the PS-side AXI-to-APB bridge; port 1 is an FPGA-local sequencer such as a mailbox/fuse loader.
Fair round-robin arbitration, one full transfer per grant, registered downstream outputs, and a hung-transfer timeout that completes the upstream transfer with an error.
Sits between the interconnect and caliptra_wrapper_top inside caliptra_package_top.

Parameters:
ADDR_WIDTH, 32, APB address width, all ports
DATA_WIDTH, 32, APB data width, all ports
TIMEOUT_CYCLES, 255, max ACCESS cycles before forced error completion; 0 = timeout disabled
CNT_WIDTH, 8, timeout counter width; must hold TIMEOUT_CYCLES

Ports:
core_clk  in  1  clock
core_rst  in  1  reset; asynchronous assert, active-high
up_psel  in  2  per-requester PSEL (bit i = port i)
up_penable  in  2  per-requester PENABLE
up_pwrite  in  2  per-requester PWRITE
up_pprot  in  2x3  per-requester PPROT
up_paddr  in  2xADDR_WIDTH  per-requester PADDR
up_pwdata  in  2xDATA_WIDTH  per-requester PWDATA
up_pready  out  2  per-requester PREADY
up_prdata  out  DATA_WIDTH  read data, shared; valid only with the granted up_pready bit
up_pslverr  out  2  per-requester PSLVERR
dn_psel  out  1  to Caliptra PSEL
dn_penable  out  1  to Caliptra PENABLE
dn_pwrite  out  1  to Caliptra PWRITE
dn_pprot  out  3  to Caliptra PPROT
dn_paddr  out  ADDR_WIDTH  to Caliptra PADDR
dn_pwdata  out  DATA_WIDTH  to Caliptra PWDATA
dn_prdata  in  DATA_WIDTH  from Caliptra PRDATA
dn_pready  in  1  from Caliptra PREADY
dn_pslverr  in  1  from Caliptra PSLVERR
grant_id  out  1  requester owning the current/last transfer
timeout_pulse  out  1  one-cycle pulse on a forced timeout completion

Behaviour:
- Reset (core_rst=1, async):
  - state=IDLE; every output 0; last_grant=1, so port 0 wins the first contention; timeout counter 0.
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs registered or decoded from state.
- IDLE:
  - Requests are sampled from up_psel only.
  - One bit set: grant that port.
  - Both set: grant ~last_grant.
  - On grant: latch the granted port's paddr/pwrite/pprot/pwdata into dn_* registers, set grant_id and last_grant, go to SETUP.
  - No request: stay in IDLE.
- SETUP (exactly 1 cycle): dn_psel=1, dn_penable=0; go to ACCESS. Counter cleared.
- ACCESS:
  - dn_psel=1, dn_penable=1.
  - dn_pready=1 at the clock edge: capture dn_prdata and dn_pslverr, go to RESP.
  - Otherwise: counter increments.
  - TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 with dn_pready=0: go to RESP with captured data=0, slverr=1. timeout_pulse=1 for that RESP cycle.
  - dn_pready and timeout on the same edge: dn_pready wins (normal completion).
- RESP (exactly 1 cycle):
  - dn_psel=0, dn_penable=0.
  - up_pready[grant_id]=1, up_pslverr[grant_id]=captured slverr, up_prdata=captured data.
  - Other port's pready/pslverr=0. Go to IDLE.
- Outside RESP: up_pready=0, up_pslverr=0, up_prdata=0.
- Latency, zero-wait completer: request sampled at edge 0 -> SETUP cycle 1 -> ACCESS cycle 2 -> RESP cycle 3 -> IDLE cycle 4. Each completer wait state adds 1 cycle.
- Fairness:
  - RESP always returns to IDLE, so an upstream back-to-back setup is sampled in IDLE.
  - With both ports continuously requesting, grants strictly alternate 0,1,0,1.
  - A lone requester gets consecutive grants.
- Upstream protocol errors:
  - Granted port drops up_psel mid-transfer: the downstream transfer still completes; the RESP pulse is still driven and ignored by that requester.
  - up_penable is not checked.
- Downstream data is latched at grant; upstream changes during the transfer do not affect dn_*.
- Reset asserted mid-transfer: dn_psel/dn_penable drop immediately (async). No upstream pready is issued for the aborted transfer.

Test Plan:
- Port 0 read, addr 0x3003_0000, zero-wait completer returning 0xDEAD_BEEF -> dn_psel rises cycle 1, dn_penable cycle 2, up_pready[0]=1 with up_prdata=0xDEAD_BEEF cycle 3; up_pready[1] stays 0.
- Both ports request writes simultaneously from reset (p0 0x10/0x1111, p1 0x20/0x2222), both re-request 3 times -> downstream order p0,p1,p0,p1,p0,p1; addr/data match the owner each time; grant_id toggles.
- Port 1 write with completer inserting 5 wait states and pslverr=1 -> dn_penable held 6 cycles; up_pready[1] and up_pslverr[1] high 1 cycle after dn_pready.
- TIMEOUT_CYCLES=4, completer never asserts pready -> 4 ACCESS cycles, then RESP with up_pslverr=1, up_prdata=0, timeout_pulse=1 for one cycle; the next request from the other port proceeds normally.
- dn_pready asserted exactly at cycle TIMEOUT_CYCLES of ACCESS -> normal completion, pslverr from completer, timeout_pulse=0.
- core_rst pulsed during ACCESS of a port 0 read -> dn_psel/dn_penable 0 without waiting for an edge; no up_pready; after release, a simultaneous request grants port 0 first.
